// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Requester 0 is instruction fetch and requester 1 is load/store.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ram_arb_state_t;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DATA   = 1;
    localparam int NUM_REQ    = 2;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: the valid/ready request channel,
// the response pulse and the busy flag.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ram_arb_pkg::NUM_REQ-1:0]                 req_valid;
    logic [ram_arb_pkg::NUM_REQ-1:0]                 req_ready;
    logic [ram_arb_pkg::NUM_REQ-1:0]                 req_write;
    logic [ram_arb_pkg::NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [ram_arb_pkg::NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [ram_arb_pkg::NUM_REQ-1:0]                 resp_valid;
    logic [DATA_WIDTH-1:0]                           resp_rdata;
    logic                                            busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/ram_arb_select.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// a tie goes to the requester that was not granted last time.
module ram_arb_select
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic               grant_idx
);

    always_comb begin
        grant_idx = 1'(REQ_IFETCH);
        grant_oh  = '0;
        case (req_valid)
            2'b01:   grant_idx = 1'(REQ_IFETCH);
            2'b10:   grant_idx = 1'(REQ_DATA);
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'(REQ_IFETCH);
        endcase
        if (req_valid != '0) begin
            grant_oh = 2'b01 << grant_idx;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises ifetch and load/store accesses onto one single-port RAM:
// one-cycle strobe, wait out the read latency, one-cycle response pulse.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    ram_arb_state_t        state_q, state_d;
    logic                  last_grant_q;
    logic                  grant_q;
    logic                  write_q;
    logic [CNT_W-1:0]      lat_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  grant_idx;
    logic                  hs;

    ram_arb_select u_select (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx)
    );

    assign hs = (state_q == IDLE) && ((bus.req_valid & grant_oh) != '0);

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.resp_rdata = rdata_q;
        bus.busy       = 1'b1;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                // Reset is IDLE too, so ready is also held off while rst is low.
                if (rst) begin
                    bus.req_ready = grant_oh;
                end
                if (hs) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_read  = ~write_q;
                ram_write = write_q;
                state_d   = write_q ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 2'b01 << grant_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            lat_cnt      <= '0;
            rdata_q      <= '0;
            ram_address  <= '0;
            ram_data_in  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        grant_q      <= grant_idx;
                        last_grant_q <= grant_idx;
                        write_q      <= bus.req_write[grant_idx];
                        ram_address  <= bus.req_addr[grant_idx];
                        ram_data_in  <= bus.req_wdata[grant_idx];
                    end
                end
                ISSUE: begin
                    lat_cnt <= CNT_W'(READ_LATENCY - 1);
                    if (write_q) begin
                        rdata_q <= '0;
                    end
                end
                WAIT: begin
                    // Count 0 is the cycle the RAM presents the read data.
                    if (lat_cnt == '0) begin
                        rdata_q <= ram_data_out;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with identical requester traffic and
// checks them cycle by cycle against a transaction-timing model of the arbiter.
module tb_ram_arbiter;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [1:0]            req_valid = '0;
    logic [1:0]            req_write = '0;
    logic [1:0][31:0]      req_addr  = '0;
    logic [1:0][31:0]      req_wdata = '0;
    int                    cyc = 0;
    int                    n_vec = 0;
    int                    n_err = 0;
    logic [1:0][102:0]     outs_all;
    logic [1:0]            busy_all;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEAD_BEEF;
            8'h08:   return 32'h1234_5678;
            default: return {a, ~a, a ^ 8'h3C, 8'hC3};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
        logic [31:0] ram_address, ram_data_in, ram_data_out;
        logic        ram_read, ram_write;

        assign bus.req_valid = req_valid;
        assign bus.req_write = req_write;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;

        ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(LAT)) dut (
            .clk          (clk),
            .rst          (rst),
            .bus          (bus),
            .ram_address  (ram_address),
            .ram_data_in  (ram_data_in),
            .ram_write    (ram_write),
            .ram_read     (ram_read),
            .ram_data_out (ram_data_out)
        );

        assign outs_all[g] = {bus.req_ready, bus.resp_valid, bus.busy, ram_read, ram_write,
                              ram_address, ram_data_in, bus.resp_rdata};
        assign busy_all[g] = bus.busy;

        // RAM with LAT-cycle read pipeline; junk data outside a real read return.
        logic [31:0]  mem [256];
        logic [255:0] written = '0;
        logic [31:0]  pipe [LAT];
        always @(posedge clk) begin
            if (ram_write) begin
                mem[ram_address[7:0]]     <= ram_data_in;
                written[ram_address[7:0]] <= 1'b1;
            end
            pipe[0] <= !ram_read ? 32'hBAD0_BAD0 :
                       (written[ram_address[7:0]] ? mem[ram_address[7:0]] : init_val(ram_address[7:0]));
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_data_out = pipe[LAT-1];

        // Reference: an access granted in cycle t strobes in t+1 and responds in
        // t+2 (write) or t+2+LAT (read); the arbiter is free again after that.
        logic [31:0]  refmem [256];
        logic [255:0] ref_wr = '0;
        int           lg, resp_c, strb_c, r_idx, gi;
        logic         s_wr, idle;
        logic [31:0]  s_addr, s_wd, r_data;
        logic [1:0]   exp_rdy, exp_rv;
        always @(negedge clk) begin
            if (!rst) begin
                lg     = 1;
                resp_c = -1;
                strb_c = -1;
            end else begin
                idle    = (cyc > resp_c);
                exp_rdy = 2'b00;
                gi      = 0;
                if (idle && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) gi = (lg == 0) ? 1 : 0;
                    else                    gi = req_valid[1] ? 1 : 0;
                    exp_rdy = 2'b01 << gi;
                end
                exp_rv = (cyc == resp_c) ? (2'b01 << r_idx) : 2'b00;
                check_eq($sformatf("L%0d req_ready", LAT), bus.req_ready, exp_rdy);
                check_eq($sformatf("L%0d busy", LAT), bus.busy, !idle);
                check_eq($sformatf("L%0d ram_read", LAT), ram_read, (cyc == strb_c) && !s_wr);
                check_eq($sformatf("L%0d ram_write", LAT), ram_write, (cyc == strb_c) && s_wr);
                check_eq($sformatf("L%0d resp_valid", LAT), bus.resp_valid, exp_rv);
                if (cyc == strb_c) begin
                    check_eq($sformatf("L%0d ram_address", LAT), ram_address, s_addr);
                    if (s_wr) check_eq($sformatf("L%0d ram_data_in", LAT), ram_data_in, s_wd);
                end
                if (cyc == resp_c) begin
                    check_eq($sformatf("L%0d resp_rdata", LAT), bus.resp_rdata, r_data);
                end
                if (exp_rdy != 2'b00) begin
                    lg     = gi;
                    r_idx  = gi;
                    s_wr   = req_write[gi];
                    s_addr = req_addr[gi];
                    s_wd   = req_wdata[gi];
                    strb_c = cyc + 1;
                    resp_c = cyc + (s_wr ? 2 : 2 + LAT);
                    if (s_wr) begin
                        refmem[s_addr[7:0]] = s_wd;
                        ref_wr[s_addr[7:0]] = 1'b1;
                        r_data = 32'h0;
                    end else begin
                        r_data = ref_wr[s_addr[7:0]] ? refmem[s_addr[7:0]] : init_val(s_addr[7:0]);
                    end
                end
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk);
        #1;
        req_valid    = v;
        req_write    = w;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outs L1", outs_all[0], 0);
        check_eq("rst_outs L3", outs_all[1], 0);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        // Lone read of 0x10; the requester changes its address right after the handshake.
        step(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        step(2'b00, 2'b00, 32'h99, 32'h0, 32'h0, 32'h0);
        idle_steps(8);
        // Write then read back through the data port; then the deep-latency location.
        step(2'b10, 2'b10, 32'h0, 32'h40, 32'h0, 32'h0000_00A5);
        idle_steps(8);
        step(2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 32'h0);
        idle_steps(8);
        step(2'b01, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0);
        idle_steps(8);
        // Both requesting continuously from reset.
        req_valid   = 2'b11;
        req_addr[0] = 32'h20;
        req_addr[1] = 32'h30;
        do_reset();
        for (int i = 0; i < 30; i++) step(2'b11, 2'b00, 32'h20 + i, 32'h30 + i, 32'h0, 32'h0);
        idle_steps(8);
        // Asynchronous reset while both arbiters sit in WAIT, both requesters valid.
        step(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step(2'b11, 2'b00, 32'h20, 32'h30, 32'h0, 32'h0);
        #1;
        check_eq("busy_in_wait", busy_all, 2'b11);
        rst = 1'b0;
        #1;
        check_eq("async_rst L1", outs_all[0], 0);
        check_eq("async_rst L3", outs_all[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step(2'b11, 2'b00, 32'h50, 32'h60, 32'h0, 32'h0);
        idle_steps(6);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                 $urandom, $urandom);
        end
        idle_steps(8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port `ram` between two requesters: the instruction-fetch port (req 0) and the load/store port (req 1). Each requester uses a valid/ready request handshake and gets a one-cycle response pulse. The arbiter serialises accesses with round-robin priority, drives the RAM strobes for one cycle, waits out the RAM read latency, and returns read data to the winner.

Parameters:
- DATA_WIDTH, 32, width of RAM and requester data.
- ADDR_WIDTH, 32, width of RAM and requester address (passed through unmodified).
- READ_LATENCY, 1, cycles from the `ram_read` strobe to valid `ram_data_out`; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit 0 = ifetch, bit 1 = data.
- req_ready  out  2  per-requester request accepted; one-hot or zero.
- req_write  in  2  per-requester op: 1 = write, 0 = read.
- req_addr  in  2 x ADDR_WIDTH  per-requester address.
- req_wdata  in  2 x DATA_WIDTH  per-requester write data.
- resp_valid  out  2  one-cycle response pulse to the granted requester.
- resp_rdata  out  DATA_WIDTH  read data; valid only while resp_valid of a read is high.
- busy  out  1  high in every state except IDLE.
- ram_address  out  ADDR_WIDTH  to RAM `address`.
- ram_data_in  out  DATA_WIDTH  to RAM `data_in`.
- ram_write  out  1  to RAM `write`.
- ram_read  out  1  to RAM `read`.
- ram_data_out  in  DATA_WIDTH  from RAM `data_out`.

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - State goes to IDLE.
  - `req_ready`, `resp_valid`, `ram_write`, `ram_read` and `busy` go to 0.
  - `ram_address`, `ram_data_in` and `resp_rdata` go to 0.
  - `last_grant` is set to 1, so req 0 wins the first tie.
  - An in-flight access is dropped and no response is issued.
- States:
  - IDLE -> ISSUE on a handshake.
  - ISSUE -> WAIT for a read; ISSUE -> RESP for a write.
  - WAIT -> RESP when the latency counter reaches 0.
  - RESP -> IDLE.
- IDLE:
  - Grant selection is combinational from `req_valid` and `last_grant`.
  - With a single valid requester, that requester is granted.
  - With both valid, the requester != `last_grant` is granted.
  - `req_ready` is high only for the granted requester, and only in IDLE.
  - Handshake = valid & ready. On the handshake edge, register addr, wdata, write and the grant index; update `last_grant`.
- ISSUE:
  - Drive `ram_address` and `ram_data_in` from the registers.
  - Pulse exactly one of `ram_read` / `ram_write` for this single cycle.
  - Load the counter with READ_LATENCY-1.
- WAIT (reads only):
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, register `ram_data_out` into `resp_rdata`.
- RESP:
  - `resp_valid[grant]` = 1 for one cycle; `resp_rdata` is held.
  - For writes, `resp_rdata` = 0.
- Timing (handshake in cycle 0):
  - Strobe in cycle 1.
  - Write response in cycle 2.
  - Read response in cycle 2+READ_LATENCY.
  - The next handshake comes no earlier than the cycle after RESP.
- RAM strobes are 0 outside ISSUE. `ram_address` and `ram_data_in` hold their last value.
- Responses have no backpressure; requesters must accept `resp_valid`.
- A requester dropping `req_valid` before the handshake is legal and has no effect.
- The arbiter captures operands only at the handshake; later changes on `req_*` are ignored.
- `req_valid` from the non-granted requester is held off (`ready`=0) until IDLE.

Decomposition:
- Shared package `ram_arb_pkg`:
  - State enum `ram_arb_state_t` {IDLE, ISSUE, WAIT, RESP}.
  - Constants REQ_IFETCH=0, REQ_DATA=1, NUM_REQ=2.
- Sub-module `ram_arb_select`: combinational 2-way round-robin grant from `req_valid` and `last_grant`. Outputs are a one-hot grant and a grant index.

Test Plan:
- Reset then lone read: req 0 read addr 0x10, where RAM holds 0xDEADBEEF; READ_LATENCY=1.
  -> `ram_read` high in cycle 1 only.
  -> `resp_valid`=2'b01 in cycle 3 with `resp_rdata`=0xDEADBEEF.
  -> `busy` high in cycles 1-3.
- Write then read back: req 1 writes 0x0000_00A5 to 0x40, then reads 0x40.
  -> Write response in cycle 2 with `resp_rdata`=0.
  -> Read returns 0x0000_00A5.
  -> `ram_write` pulses exactly once.
- Contention: both valid continuously from reset, each reading distinct addresses.
  -> Grants alternate 0,1,0,1.
  -> Each `resp_valid` bit goes only to its own requester, with the correct data.
- Latency sweep: READ_LATENCY=3, read 0x8 holding 0x12345678.
  -> `resp_valid` in cycle 5; `resp_rdata`=0x12345678.
- Reset mid-access: assert rst in the WAIT cycle.
  -> All outputs go to 0 immediately (asynchronously); no `resp_valid` after release.
  -> The next tie grants req 0.
- Operand stability: change `req_addr[0]` to 0x99 in the cycle after the handshake for 0x10.
  -> `ram_address`=0x10 in ISSUE.
